// File: rtl/lamp_mon_pkg.sv
// Shared types and constants for the lamp conflict monitor.
// Optional dark-lamp checking is enabled by defining LAMP_MON_DARK_CHECK_EN.
package lamp_mon_pkg;

    typedef logic [2:0] fault_code_t;

    localparam fault_code_t FC_NONE      = 3'd0;
    localparam fault_code_t FC_CONFLICT  = 3'd1;
    localparam fault_code_t FC_MULTI     = 3'd2;
    localparam fault_code_t FC_DARK      = 3'd3;
    localparam fault_code_t FC_SHORT_YEL = 3'd4;
    localparam fault_code_t FC_SKIP_YEL  = 3'd5;

    typedef enum logic [1:0] {
        StMonitor,
        StFault,
        StRecover
    } mon_state_e;

    typedef enum logic [2:0] {
        PhDark,
        PhGreen,
        PhYellow,
        PhRed,
        PhMulti
    } phase_e;

    typedef struct packed {
        logic ctl_reset;
        logic flash_mode;
        logic fault_ack;
        logic red_p;
        logic yel_p;
        logic grn_p;
        logic red_s;
        logic yel_s;
        logic grn_s;
    } lamp_sample_t;

    function automatic int unsigned dwell_cnt_width(int unsigned yel_min, int unsigned dark_max);
        int unsigned m;
        m = (yel_min > dark_max) ? yel_min : dark_max;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/lamp_conflict_monitor_if.sv
// Lamp/control signals from the s298 controller side and fault outputs of the monitor.
// master drives lamps and acknowledge; slave is the monitor.
interface lamp_conflict_monitor_if;
    import lamp_mon_pkg::*;

    logic        ctl_reset;
    logic        flash_mode;
    logic        red_p;
    logic        yel_p;
    logic        grn_p;
    logic        red_s;
    logic        yel_s;
    logic        grn_s;
    logic        fault_ack;
    logic        fault;
    fault_code_t fault_code;
    logic        flash_req;
    logic        mon_ok;

    modport master (
        output ctl_reset, flash_mode, red_p, yel_p, grn_p, red_s, yel_s, grn_s, fault_ack,
        input  fault, fault_code, flash_req, mon_ok
    );

    modport slave (
        input  ctl_reset, flash_mode, red_p, yel_p, grn_p, red_s, yel_s, grn_s, fault_ack,
        output fault, fault_code, flash_req, mon_ok
    );

endinterface

// File: rtl/lamp_phase_tracker.sv
// Per-direction phase decode, G->Y->R transition checks and dwell counters.
// The dark counter exists only when LAMP_MON_DARK_CHECK_EN is defined.
module lamp_phase_tracker
    import lamp_mon_pkg::*;
#(
    parameter int unsigned YEL_MIN  = 2,
    parameter int unsigned DARK_MAX = 4
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   r_i,
    input  logic   y_i,
    input  logic   g_i,
    input  logic   clr_i,
    input  logic   chk_en_i,
    output phase_e phase_o,
    output logic   dark_viol_o,
    output logic   short_yel_o,
    output logic   skip_yel_o
);

    localparam int unsigned CntW = dwell_cnt_width(YEL_MIN, DARK_MAX);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t YelMin = cnt_t'(YEL_MIN);

    phase_e prev_q, prev_d;
    logic   valid_q, valid_d;
    cnt_t   yel_cnt_q, yel_cnt_d;
    logic   flush;

    // Suspended cycles break the history so the next sample is a fresh phase entry.
    assign flush = clr_i | ~chk_en_i;

    always_comb begin
        phase_o = PhMulti;
        unique case ({r_i, y_i, g_i})
            3'b000:  phase_o = PhDark;
            3'b100:  phase_o = PhRed;
            3'b010:  phase_o = PhYellow;
            3'b001:  phase_o = PhGreen;
            default: phase_o = PhMulti;
        endcase
    end

    always_comb begin
        prev_d    = phase_o;
        valid_d   = 1'b1;
        yel_cnt_d = '0;
        if (phase_o == PhYellow) begin
            yel_cnt_d = (yel_cnt_q == '1) ? yel_cnt_q : yel_cnt_q + 1'b1;
        end
        if (flush) begin
            valid_d   = 1'b0;
            yel_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q    <= PhDark;
            valid_q   <= 1'b0;
            yel_cnt_q <= '0;
        end else begin
            prev_q    <= prev_d;
            valid_q   <= valid_d;
            yel_cnt_q <= yel_cnt_d;
        end
    end

    assign skip_yel_o  = chk_en_i && valid_q && (prev_q == PhGreen) && (phase_o == PhRed);
    assign short_yel_o = chk_en_i && valid_q && (prev_q == PhYellow) && (phase_o == PhRed) &&
                         (yel_cnt_q < YelMin);

`ifdef LAMP_MON_DARK_CHECK_EN
    localparam cnt_t DarkMax = cnt_t'(DARK_MAX);

    cnt_t dark_cnt_q, dark_cnt_d;

    always_comb begin
        dark_cnt_d = '0;
        if (!flush && (phase_o == PhDark)) begin
            dark_cnt_d = (dark_cnt_q == '1) ? dark_cnt_q : dark_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dark_cnt_q <= '0;
        end else begin
            dark_cnt_q <= dark_cnt_d;
        end
    end

    // dark_cnt_q counts earlier dark samples; this one makes DARK_MAX+1.
    assign dark_viol_o = chk_en_i && (phase_o == PhDark) && (dark_cnt_q >= DarkMax);
`else
    assign dark_viol_o = 1'b0;
`endif

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Lamp conflict monitor downstream of the s298 controller: samples lamps, latches the first
// violation and requests blink mode until acknowledged. Dark check: LAMP_MON_DARK_CHECK_EN.
module lamp_conflict_monitor
    import lamp_mon_pkg::*;
#(
    parameter int unsigned YEL_MIN     = 2,
    parameter int unsigned DARK_MAX    = 4,
    parameter int unsigned RECOVER_CYC = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    lamp_conflict_monitor_if.slave mon_if
);

    localparam int unsigned RcntW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [RcntW-1:0] RcntLast = RcntW'(RECOVER_CYC - 1);

    lamp_sample_t     samp_q, samp_d;
    mon_state_e       state_q, state_d;
    fault_code_t      code_q, code_d;
    logic [RcntW-1:0] rcnt_q, rcnt_d;

    phase_e      phase_p, phase_s;
    logic        dark_p, dark_s, short_p, short_s, skip_p, skip_s;
    logic        chk_lamp_en, chk_seq_en, trk_clr, enter_mon;
    logic        conflict, multi;
    fault_code_t viol_code;
    logic        fault, flash_req, mon_ok;
    fault_code_t fault_code;

    always_comb begin
        samp_d.ctl_reset  = mon_if.ctl_reset;
        samp_d.flash_mode = mon_if.flash_mode;
        samp_d.fault_ack  = mon_if.fault_ack;
        samp_d.red_p      = mon_if.red_p;
        samp_d.yel_p      = mon_if.yel_p;
        samp_d.grn_p      = mon_if.grn_p;
        samp_d.red_s      = mon_if.red_s;
        samp_d.yel_s      = mon_if.yel_s;
        samp_d.grn_s      = mon_if.grn_s;
    end

    assign chk_lamp_en = ~samp_q.ctl_reset;
    assign chk_seq_en  = ~samp_q.ctl_reset & ~samp_q.flash_mode;
    assign enter_mon   = (state_q == StRecover) && (rcnt_q == RcntLast);
    assign trk_clr     = samp_q.ctl_reset | enter_mon;

    lamp_phase_tracker #(
        .YEL_MIN  (YEL_MIN),
        .DARK_MAX (DARK_MAX)
    ) u_trk_p (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .r_i         (samp_q.red_p),
        .y_i         (samp_q.yel_p),
        .g_i         (samp_q.grn_p),
        .clr_i       (trk_clr),
        .chk_en_i    (chk_seq_en),
        .phase_o     (phase_p),
        .dark_viol_o (dark_p),
        .short_yel_o (short_p),
        .skip_yel_o  (skip_p)
    );

    lamp_phase_tracker #(
        .YEL_MIN  (YEL_MIN),
        .DARK_MAX (DARK_MAX)
    ) u_trk_s (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .r_i         (samp_q.red_s),
        .y_i         (samp_q.yel_s),
        .g_i         (samp_q.grn_s),
        .clr_i       (trk_clr),
        .chk_en_i    (chk_seq_en),
        .phase_o     (phase_s),
        .dark_viol_o (dark_s),
        .short_yel_o (short_s),
        .skip_yel_o  (skip_s)
    );

    // Both directions showing a go-aspect (yellow or green) is a conflict.
    assign conflict = chk_lamp_en &&
                      (((samp_q.yel_p | samp_q.grn_p) && (samp_q.yel_s | samp_q.grn_s)) ||
                       (samp_q.grn_p && samp_q.grn_s));
    assign multi    = chk_lamp_en && ((phase_p == PhMulti) || (phase_s == PhMulti));

    always_comb begin
        viol_code = FC_NONE;
        if (conflict) begin
            viol_code = FC_CONFLICT;
        end else if (multi) begin
            viol_code = FC_MULTI;
        end else if (dark_p || dark_s) begin
            viol_code = FC_DARK;
        end else if (short_p || short_s) begin
            viol_code = FC_SHORT_YEL;
        end else if (skip_p || skip_s) begin
            viol_code = FC_SKIP_YEL;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        rcnt_d     = rcnt_q;
        fault      = 1'b0;
        fault_code = FC_NONE;
        flash_req  = 1'b0;
        mon_ok     = 1'b0;
        unique case (state_q)
            StMonitor: begin
                mon_ok = 1'b1;
                if (viol_code != FC_NONE) begin
                    state_d = StFault;
                    code_d  = viol_code;
                end
            end
            StFault: begin
                fault      = 1'b1;
                fault_code = code_q;
                flash_req  = 1'b1;
                if (samp_q.fault_ack && (viol_code == FC_NONE)) begin
                    state_d = StRecover;
                    rcnt_d  = '0;
                end
            end
            StRecover: begin
                flash_req = 1'b1;
                if (enter_mon) begin
                    state_d = StMonitor;
                    code_d  = FC_NONE;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: state_d = StMonitor;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            samp_q  <= '0;
            state_q <= StMonitor;
            code_q  <= FC_NONE;
            rcnt_q  <= '0;
        end else begin
            samp_q  <= samp_d;
            state_q <= state_d;
            code_q  <= code_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign mon_if.fault      = fault;
    assign mon_if.fault_code = fault_code;
    assign mon_if.flash_req  = flash_req;
    assign mon_if.mon_ok     = mon_ok;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Self-checking bench for lamp_conflict_monitor: directed scenarios followed by random lamp
// traffic, compared every cycle against a sample-history reference model.
module tb_lamp_conflict_monitor;
    import lamp_mon_pkg::*;

    localparam int YEL_MIN     = 2;
    localparam int DARK_MAX    = 4;
    localparam int RECOVER_CYC = 8;

    // Lamp vector order: {red_p, yel_p, grn_p, red_s, yel_s, grn_s}
    localparam bit [5:0] ALL_R  = 6'b100_100;
    localparam bit [5:0] PG     = 6'b001_100;
    localparam bit [5:0] PY     = 6'b010_100;
    localparam bit [5:0] SG     = 6'b100_001;
    localparam bit [5:0] SY     = 6'b100_010;
    localparam bit [5:0] BOTH_G = 6'b001_001;
    localparam bit [5:0] S_DARK = 6'b100_000;

    typedef struct {
        bit [5:0] lamps;
        bit       flash;
        bit       ctl;
        bit       ack;
    } smp_t;

    logic clk;
    logic reset;

    lamp_conflict_monitor_if mon_if ();

    lamp_conflict_monitor #(
        .YEL_MIN     (YEL_MIN),
        .DARK_MAX    (DARK_MAX),
        .RECOVER_CYC (RECOVER_CYC)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .mon_if  (mon_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    smp_t hist[$];
    int   floor_idx;
    int   m_state;  // 0 monitoring, 1 fault latched, 2 recovering
    int   m_code;
    int   m_left;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic bit [2:0] dir_lamps(input smp_t s, input int d);
        bit [5:0] l;
        l = s.lamps;
        return (d == 0) ? l[5:3] : l[2:0];
    endfunction

    function automatic bit usable(input int j);
        return (j >= floor_idx) && !hist[j].ctl && !hist[j].flash;
    endfunction

    function automatic int run_of(input int i, input int d, input bit [2:0] pat);
        int n;
        int j;
        n = 0;
        j = i;
        while (usable(j) && (dir_lamps(hist[j], d) == pat)) begin
            n++;
            j--;
        end
        return n;
    endfunction

    // Lowest-numbered violation present in sample i, judged from the lamp rules directly.
    function automatic int viol(input int i);
        smp_t     s;
        bit [2:0] p;
        bit [2:0] q;
        bit [2:0] cur;
        bit [2:0] prv;
        bit       dk;
        bit       sh;
        bit       sk;
        s  = hist[i];
        p  = dir_lamps(s, 0);
        q  = dir_lamps(s, 1);
        dk = 1'b0;
        sh = 1'b0;
        sk = 1'b0;
        if (s.ctl) return 0;
        if ((p[1] | p[0]) && (q[1] | q[0])) return 1;
        if ($countones(p) > 1 || $countones(q) > 1) return 2;
        if (s.flash) return 0;
        for (int d = 0; d < 2; d++) begin
            cur = dir_lamps(s, d);
`ifdef LAMP_MON_DARK_CHECK_EN
            if (cur == 3'b000 && run_of(i, d, 3'b000) > DARK_MAX) dk = 1'b1;
`endif
            if (cur == 3'b100 && usable(i - 1)) begin
                prv = dir_lamps(hist[i - 1], d);
                if (prv == 3'b001) sk = 1'b1;
                if (prv == 3'b010 && run_of(i - 1, d, 3'b010) < YEL_MIN) sh = 1'b1;
            end
        end
        if (dk) return 3;
        if (sh) return 4;
        if (sk) return 5;
        return 0;
    endfunction

    task automatic model_edge(input bit rst, input smp_t s);
        smp_t z;
        int   cur;
        int   v;
        if (rst) begin
            z = '{lamps: 6'b0, flash: 1'b0, ctl: 1'b0, ack: 1'b0};
            hist.delete();
            hist.push_back(z);
            floor_idx = 0;
            m_state   = 0;
            m_code    = 0;
            m_left    = 0;
        end else begin
            cur = hist.size() - 1;
            v   = viol(cur);
            case (m_state)
                0: if (v != 0) begin
                    m_state = 1;
                    m_code  = v;
                end
                1: if (hist[cur].ack && v == 0) begin
                    m_state = 2;
                    m_left  = RECOVER_CYC;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_state   = 0;
                        floor_idx = cur + 1;
                    end
                end
            endcase
            hist.push_back(s);
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit [5:0] lamps, input bit flash, input bit ctl,
                        input bit ack);
        smp_t s;
        reset             = rst;
        mon_if.red_p      = lamps[5];
        mon_if.yel_p      = lamps[4];
        mon_if.grn_p      = lamps[3];
        mon_if.red_s      = lamps[2];
        mon_if.yel_s      = lamps[1];
        mon_if.grn_s      = lamps[0];
        mon_if.flash_mode = flash;
        mon_if.ctl_reset  = ctl;
        mon_if.fault_ack  = ack;
        s.lamps           = lamps;
        s.flash           = flash;
        s.ctl             = ctl;
        s.ack             = ack;
        @(posedge clk);
        #1;
        model_edge(rst, s);
        chk("model_fault", {2'b0, mon_if.fault}, {2'b0, m_state == 1});
        chk("model_code", mon_if.fault_code, (m_state == 1) ? 3'(m_code) : 3'd0);
        chk("model_flash_req", {2'b0, mon_if.flash_req}, {2'b0, m_state != 0});
        chk("model_mon_ok", {2'b0, mon_if.mon_ok}, {2'b0, m_state == 0});
    endtask

    task automatic hold(input int n, input bit [5:0] lamps, input bit flash);
        for (int i = 0; i < n; i++) step(1'b0, lamps, flash, 1'b0, 1'b0);
    endtask

    task automatic recover();
        hold(2, ALL_R, 1'b0);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b1);
        hold(RECOVER_CYC + 1, ALL_R, 1'b0);
    endtask

    initial begin
        bit [5:0] legal[5];
        bit [5:0] pat;
        legal[0] = ALL_R;
        legal[1] = PG;
        legal[2] = PY;
        legal[3] = SG;
        legal[4] = SY;

        // Reset values
        step(1'b1, ALL_R, 1'b0, 1'b0, 1'b0);
        step(1'b1, ALL_R, 1'b0, 1'b0, 1'b0);
        chk("reset_fault", {2'b0, mon_if.fault}, 3'd0);
        chk("reset_code", mon_if.fault_code, 3'd0);
        chk("reset_flash_req", {2'b0, mon_if.flash_req}, 3'd0);
        chk("reset_mon_ok", {2'b0, mon_if.mon_ok}, 3'd1);
        hold(3, ALL_R, 1'b0);

        // Legal G(5) Y(3) R(6) on each direction in turn
        hold(5, PG, 1'b0);
        hold(3, PY, 1'b0);
        hold(6, ALL_R, 1'b0);
        hold(5, SG, 1'b0);
        hold(3, SY, 1'b0);
        hold(6, ALL_R, 1'b0);
        chk("legal_fault", {2'b0, mon_if.fault}, 3'd0);
        chk("legal_mon_ok", {2'b0, mon_if.mon_ok}, 3'd1);

        // Both greens for one sample: fault two edges after presentation
        step(1'b0, BOTH_G, 1'b0, 1'b0, 1'b0);
        chk("conflict_latency", {2'b0, mon_if.fault}, 3'd0);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b0);
        chk("conflict_fault", {2'b0, mon_if.fault}, 3'd1);
        chk("conflict_code", mon_if.fault_code, 3'd1);
        chk("conflict_flash_req", {2'b0, mon_if.flash_req}, 3'd1);
        recover();

        // Short yellow, then the same with blink mode active
        hold(3, PG, 1'b0);
        step(1'b0, PY, 1'b0, 1'b0, 1'b0);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b0);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b0);
        chk("short_yel_code", mon_if.fault_code, 3'd4);
        recover();
        hold(3, PG, 1'b1);
        step(1'b0, PY, 1'b1, 1'b0, 1'b0);
        hold(3, ALL_R, 1'b1);
        chk("short_yel_flash_fault", {2'b0, mon_if.fault}, 3'd0);
        hold(2, ALL_R, 1'b0);

        // Skipped yellow followed by a conflict keeps the first code
        hold(3, PG, 1'b0);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b0);
        step(1'b0, BOTH_G, 1'b0, 1'b0, 1'b0);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b0);
        chk("skip_yel_code", mon_if.fault_code, 3'd5);
        recover();

        // Secondary dark for five samples
        hold(5, S_DARK, 1'b0);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b0);
`ifdef LAMP_MON_DARK_CHECK_EN
        chk("dark_code", mon_if.fault_code, 3'd3);
`else
        chk("dark_disabled_mon_ok", {2'b0, mon_if.mon_ok}, 3'd1);
`endif
        recover();

        // Acknowledge during a live violation is ignored; ctl_reset keeps the fault
        step(1'b0, BOTH_G, 1'b0, 1'b0, 1'b0);
        step(1'b0, BOTH_G, 1'b0, 1'b0, 1'b0);
        step(1'b0, BOTH_G, 1'b0, 1'b0, 1'b1);
        step(1'b0, BOTH_G, 1'b0, 1'b0, 1'b0);
        chk("ack_ignored_fault", {2'b0, mon_if.fault}, 3'd1);
        step(1'b0, ALL_R, 1'b0, 1'b1, 1'b0);
        step(1'b0, ALL_R, 1'b0, 1'b1, 1'b0);
        chk("ctl_reset_fault", {2'b0, mon_if.fault}, 3'd1);
        chk("ctl_reset_code", mon_if.fault_code, 3'd1);
        hold(2, ALL_R, 1'b0);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b1);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b0);
        chk("ack_fault_drop", {2'b0, mon_if.fault}, 3'd0);
        chk("ack_flash_held", {2'b0, mon_if.flash_req}, 3'd1);
        for (int i = 0; i < RECOVER_CYC - 1; i++) begin
            step(1'b0, ALL_R, 1'b0, 1'b0, 1'b0);
            chk("recover_flash_held", {2'b0, mon_if.flash_req}, 3'd1);
        end
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b0);
        chk("recover_flash_drop", {2'b0, mon_if.flash_req}, 3'd0);
        chk("recover_mon_ok", {2'b0, mon_if.mon_ok}, 3'd1);

        // Reset in the middle of recovery
        step(1'b0, BOTH_G, 1'b0, 1'b0, 1'b0);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b0);
        hold(2, ALL_R, 1'b0);
        step(1'b0, ALL_R, 1'b0, 1'b0, 1'b1);
        hold(3, ALL_R, 1'b0);
        chk("mid_recover_flash", {2'b0, mon_if.flash_req}, 3'd1);
        step(1'b1, ALL_R, 1'b0, 1'b0, 1'b0);
        chk("mid_reset_fault", {2'b0, mon_if.fault}, 3'd0);
        chk("mid_reset_flash_req", {2'b0, mon_if.flash_req}, 3'd0);
        chk("mid_reset_mon_ok", {2'b0, mon_if.mon_ok}, 3'd1);
        hold(3, ALL_R, 1'b0);

        // Random traffic: mostly legal aspects with dwell, occasional faults and controls
        pat = ALL_R;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 30) begin
                if ($urandom_range(0, 99) < 85) pat = legal[$urandom_range(0, 4)];
                else pat = 6'($urandom_range(0, 63));
            end
            step($urandom_range(0, 199) == 0, pat,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 15);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
